// File: rtl/nrisc_data_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding,
// requester indices and the legal memory-latency range.
package nrisc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_EXT = 1'b1;

    // Read latency the arbiter can be built for; the counter is sized to cover it.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/nrisc_data_arbiter_if.sv
// Requester and memory-side signals of the data arbiter.
// master = arbiter side, slave = requesters plus memory macro.
interface nrisc_data_arbiter_if #(parameter int TAM = 16);

    logic           cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [TAM-1:0] cpu_addr, cpu_wdata;
    logic           ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [TAM-1:0] ext_addr, ext_wdata;
    logic [TAM-1:0] rdata;
    logic           mem_en, mem_we;
    logic [TAM-1:0] mem_addr, mem_wdata, mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/nrisc_data_arbiter_rr_pick.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to
// whichever side was not served last.
module nrisc_rr_pick
    import nrisc_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ext_req,
    input  logic last,
    output logic pick
);

    // Pick the winner among the currently asserted requests.
    always_comb begin
        pick = REQ_CPU;
        if (cpu_req && ext_req)
            pick = ~last;
        else if (ext_req)
            pick = REQ_EXT;
    end

endmodule

// File: rtl/nrisc_data_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store path and an
// external requester. One access in flight at a time; reads return data
// with an rvalid pulse MEM_LAT cycles after the grant.
module nrisc_data_arbiter
    import nrisc_arb_pkg::*;
#(
    parameter int TAM     = 16,
    parameter int MEM_LAT = 1      // legal MEM_LAT_MIN..MEM_LAT_MAX
) (
    input logic                  clk,
    input logic                  rst,
    nrisc_data_arbiter_if.master bus
);

    arb_state_t       state;
    logic             owner;
    logic             last_srv;
    logic             pick;
    logic [CNT_W-1:0] cnt;
    logic             rd_done;

    nrisc_rr_pick u_pick (
        .cpu_req (bus.cpu_req),
        .ext_req (bus.ext_req),
        .last    (last_srv),
        .pick    (pick)
    );

    // Read data is passed straight through from memory in the final WAIT cycle.
    assign rd_done        = (state == WAIT) && (cnt == CNT_W'(MEM_LAT));
    assign bus.cpu_rvalid = rd_done && (owner == REQ_CPU);
    assign bus.ext_rvalid = rd_done && (owner == REQ_EXT);
    assign bus.rdata      = rd_done ? bus.mem_rdata : '0;

    // Arbitration FSM; mem_addr/mem_wdata double as the latched request so
    // requesters may change their inputs once gnt is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= REQ_CPU;
            last_srv      <= REQ_EXT;
            cnt           <= '0;
            bus.cpu_gnt   <= 1'b0;
            bus.ext_gnt   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.ext_req) begin
                        state         <= GRANT;
                        owner         <= pick;
                        last_srv      <= pick;
                        bus.cpu_gnt   <= (pick == REQ_CPU);
                        bus.ext_gnt   <= (pick == REQ_EXT);
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= (pick == REQ_EXT) ? bus.ext_we    : bus.cpu_we;
                        bus.mem_addr  <= (pick == REQ_EXT) ? bus.ext_addr  : bus.cpu_addr;
                        bus.mem_wdata <= (pick == REQ_EXT) ? bus.ext_wdata : bus.cpu_wdata;
                    end
                end
                GRANT: begin
                    bus.cpu_gnt <= 1'b0;
                    bus.ext_gnt <= 1'b0;
                    bus.mem_en  <= 1'b0;
                    bus.mem_we  <= 1'b0;
                    cnt         <= CNT_W'(1);
                    state       <= bus.mem_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (rd_done)
                        state <= IDLE;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_data_arbiter.sv
// Directed bench for nrisc_data_arbiter: one instance with MEM_LAT = 1 and
// one with MEM_LAT = 3, each behind a small latency-accurate memory model.
module tb_nrisc_data_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nrisc_data_arbiter_if #(.TAM(16)) if1 ();
    nrisc_data_arbiter_if #(.TAM(16)) if3 ();

    nrisc_data_arbiter #(.TAM(16), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    nrisc_data_arbiter #(.TAM(16), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Memory contents: 0x0020 holds 0x1234, everything else addr ^ 0xA5A5.
    function automatic logic [15:0] memval(input logic [15:0] a);
        return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Memory models: read sampled with mem_en, data valid MEM_LAT cycles later.
    logic [15:0] rd1, p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        if (if1.mem_en && !if1.mem_we) rd1 <= memval(if1.mem_addr);
        p3_0 <= (if3.mem_en && !if3.mem_we) ? memval(if3.mem_addr) : 16'h0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign if1.mem_rdata = rd1;
    assign if3.mem_rdata = p3_2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({if1.cpu_gnt, if1.ext_gnt, if1.cpu_rvalid, if1.ext_rvalid, if1.mem_en, if1.mem_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl1: got %b expected 000000",
                {if1.cpu_gnt, if1.ext_gnt, if1.cpu_rvalid, if1.ext_rvalid, if1.mem_en, if1.mem_we});
        end
        checks++;
        if ({if1.mem_addr, if1.mem_wdata} !== 32'h0) begin
            errors++; $display("FAIL reset_bus1: got %h expected 0", {if1.mem_addr, if1.mem_wdata});
        end
        checks++;
        if ({if3.cpu_gnt, if3.ext_gnt, if3.mem_en, if3.mem_we, if3.mem_addr} !== 20'h0) begin
            errors++; $display("FAIL reset_dut3: got %h expected 0",
                {if3.cpu_gnt, if3.ext_gnt, if3.mem_en, if3.mem_we, if3.mem_addr});
        end
    endtask

    task automatic test_write;
        int rv = 0;
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b1; if1.cpu_addr = 16'h0010; if1.cpu_wdata = 16'hBEEF;
        tick;
        checks++;
        if ({if1.cpu_gnt, if1.ext_gnt, if1.mem_en, if1.mem_we} !== 4'b1011) begin
            errors++; $display("FAIL write_gnt: got %b expected 1011",
                {if1.cpu_gnt, if1.ext_gnt, if1.mem_en, if1.mem_we});
        end
        checks++;
        if (if1.mem_addr !== 16'h0010 || if1.mem_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL write_bus: got %h/%h expected 0010/beef", if1.mem_addr, if1.mem_wdata);
        end
        if1.cpu_req = 1'b0;
        tick;
        checks++;
        if ({if1.cpu_gnt, if1.mem_en, if1.mem_we} !== 3'b000) begin
            errors++; $display("FAIL write_one_cycle: got %b expected 000", {if1.cpu_gnt, if1.mem_en, if1.mem_we});
        end
        for (int i = 0; i < 4; i++) begin
            if (if1.cpu_rvalid) rv++;
            tick;
        end
        checks++;
        if (rv !== 0) begin
            errors++; $display("FAIL write_no_rvalid: got %0d pulses expected 0", rv);
        end
    endtask

    task automatic test_ext_read;
        if1.ext_req = 1'b1; if1.ext_we = 1'b0; if1.ext_addr = 16'h0020; if1.ext_wdata = 16'h0;
        tick;
        checks++;
        if ({if1.cpu_gnt, if1.ext_gnt, if1.mem_en, if1.mem_we} !== 4'b0110 || if1.mem_addr !== 16'h0020) begin
            errors++; $display("FAIL read_gnt: got %b addr %h expected 0110 addr 0020",
                {if1.cpu_gnt, if1.ext_gnt, if1.mem_en, if1.mem_we}, if1.mem_addr);
        end
        if1.ext_req = 1'b0;
        tick;
        checks++;
        if ({if1.ext_rvalid, if1.cpu_rvalid} !== 2'b10 || if1.rdata !== 16'h1234) begin
            errors++; $display("FAIL read_rvalid: got %b rdata %h expected 10 rdata 1234",
                {if1.ext_rvalid, if1.cpu_rvalid}, if1.rdata);
        end
        tick;
        checks++;
        if (if1.ext_rvalid !== 1'b0 || u_dut1.state !== 2'd0) begin
            errors++; $display("FAIL read_idle: got rvalid %b state %0d expected 0/0", if1.ext_rvalid, u_dut1.state);
        end
    endtask

    task automatic test_back_to_back;
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b1; if1.cpu_addr = 16'h0030; if1.cpu_wdata = 16'h0C0C;
        if1.ext_req = 1'b1; if1.ext_we = 1'b1; if1.ext_addr = 16'h0031; if1.ext_wdata = 16'h0E0E;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if ({if1.cpu_gnt, if1.ext_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL tie_order[%0d]: got cpu/ext %b expected %b", k,
                    {if1.cpu_gnt, if1.ext_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (k == 3) begin if1.cpu_req = 1'b0; if1.ext_req = 1'b0; end
            tick;
            checks++;
            if ({if1.cpu_gnt, if1.ext_gnt} !== 2'b00) begin
                errors++; $display("FAIL tie_gap[%0d]: got %b expected 00", k, {if1.cpu_gnt, if1.ext_gnt});
            end
        end
    endtask

    task automatic test_hold;
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b1; if1.cpu_addr = 16'h0100; if1.cpu_wdata = 16'h1111;
        tick;
        if1.cpu_req = 1'b0; if1.cpu_addr = 16'hFFFF; if1.cpu_wdata = 16'h2222;
        #1;
        checks++;
        if (if1.cpu_gnt !== 1'b1 || if1.mem_addr !== 16'h0100 || if1.mem_wdata !== 16'h1111) begin
            errors++; $display("FAIL hold_gnt: got gnt %b %h/%h expected 1 0100/1111",
                if1.cpu_gnt, if1.mem_addr, if1.mem_wdata);
        end
        tick;
        checks++;
        if (if1.mem_addr !== 16'h0100 || if1.mem_wdata !== 16'h1111) begin
            errors++; $display("FAIL hold_idle: got %h/%h expected 0100/1111", if1.mem_addr, if1.mem_wdata);
        end
    endtask

    task automatic test_wait_block;
        if3.cpu_req = 1'b1; if3.cpu_we = 1'b0; if3.cpu_addr = 16'h0040; if3.cpu_wdata = 16'h0;
        tick;
        checks++;
        if (if3.cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL wait_cpu_gnt: got %b expected 1", if3.cpu_gnt);
        end
        if3.cpu_req = 1'b0;
        if3.ext_req = 1'b1; if3.ext_we = 1'b1; if3.ext_addr = 16'h0055; if3.ext_wdata = 16'h7777;
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++;
            if ({if3.ext_gnt, if3.cpu_rvalid, if3.ext_rvalid} !== ((i == 3) ? 3'b010 : 3'b000)) begin
                errors++; $display("FAIL wait_cycle[%0d]: got gnt/crv/erv %b expected %b", i,
                    {if3.ext_gnt, if3.cpu_rvalid, if3.ext_rvalid}, (i == 3) ? 3'b010 : 3'b000);
            end
        end
        checks++;
        if (if3.rdata !== 16'hA5E5) begin
            errors++; $display("FAIL wait_rdata: got %h expected a5e5", if3.rdata);
        end
        tick;
        checks++;
        if (if3.ext_gnt !== 1'b0) begin
            errors++; $display("FAIL wait_ext_early: got %b expected 0", if3.ext_gnt);
        end
        tick;
        checks++;
        if ({if3.ext_gnt, if3.mem_en, if3.mem_we} !== 3'b111 || if3.mem_addr !== 16'h0055) begin
            errors++; $display("FAIL wait_ext_gnt: got %b addr %h expected 111 addr 0055",
                {if3.ext_gnt, if3.mem_en, if3.mem_we}, if3.mem_addr);
        end
        if3.ext_req = 1'b0;
        tick;
    endtask

    task automatic test_reset_abort;
        int rv = 0;
        if3.cpu_req = 1'b1; if3.cpu_we = 1'b0; if3.cpu_addr = 16'h0044;
        tick;
        if3.cpu_req = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if ({if3.cpu_gnt, if3.ext_gnt, if3.cpu_rvalid, if3.ext_rvalid, if3.mem_en, if3.mem_we} !== 6'b0 ||
            {if3.mem_addr, if3.mem_wdata, if3.rdata} !== 48'h0) begin
            errors++; $display("FAIL abort_outputs: got %b %h expected all 0",
                {if3.cpu_gnt, if3.ext_gnt, if3.cpu_rvalid, if3.ext_rvalid, if3.mem_en, if3.mem_we},
                {if3.mem_addr, if3.mem_wdata, if3.rdata});
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (if3.cpu_rvalid || if3.ext_rvalid) rv++;
        end
        checks++;
        if (rv !== 0) begin
            errors++; $display("FAIL abort_no_rvalid: got %0d pulses expected 0", rv);
        end
        if3.cpu_req = 1'b1; if3.cpu_we = 1'b1; if3.cpu_addr = 16'h0060; if3.cpu_wdata = 16'h0101;
        if3.ext_req = 1'b1; if3.ext_we = 1'b1; if3.ext_addr = 16'h0061; if3.ext_wdata = 16'h0202;
        tick;
        checks++;
        if ({if3.cpu_gnt, if3.ext_gnt} !== 2'b10) begin
            errors++; $display("FAIL abort_tie: got cpu/ext %b expected 10", {if3.cpu_gnt, if3.ext_gnt});
        end
        if3.cpu_req = 1'b0; if3.ext_req = 1'b0;
        tick;
    endtask

    initial begin
        {if1.cpu_req, if1.cpu_we, if1.ext_req, if1.ext_we} = 4'b0;
        {if1.cpu_addr, if1.cpu_wdata, if1.ext_addr, if1.ext_wdata} = 64'h0;
        {if3.cpu_req, if3.cpu_we, if3.ext_req, if3.ext_we} = 4'b0;
        {if3.cpu_addr, if3.cpu_wdata, if3.ext_addr, if3.ext_wdata} = 64'h0;
        tick;
        tick;
        test_reset;
        rst = 1'b1;
        tick;
        test_write;
        test_ext_read;
        test_back_to_back;
        test_hold;
        test_wait_block;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrisc_data_arbiter.md
# nrisc_data_arbiter

Two-requester arbiter sharing the single-port data memory between the CPU load/store path and an external requester (program loader / DMA / debug port). It sits between the CPU data-memory signals and the memory macro. It issues one access at a time, alternates round-robin between simultaneous requesters, and returns read data with a valid pulse after a parameterised memory latency.

## Interface
- TAM, 16, data and address width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4): cycles from the memory sampling mem_en to mem_rdata valid
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- cpu_req / ext_req  input  1  access request; level, held until the matching gnt
- cpu_we / ext_we  input  1  1 = write, 0 = read; qualified by req
- cpu_addr / ext_addr  input  TAM  word address
- cpu_wdata / ext_wdata  input  TAM  write data
- cpu_gnt / ext_gnt  output  1  one-cycle pulse: request accepted and issued to memory this cycle
- cpu_rvalid / ext_rvalid  output  1  one-cycle pulse: rdata holds the read result
- rdata  output  TAM  read data, shared by both requesters; valid only with an rvalid
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  TAM  memory address
- mem_wdata  output  TAM  memory write data
- mem_rdata  input  TAM  memory read data

## Operation
- States:
  - IDLE: sample requests.
  - GRANT: one cycle; drive mem_en plus the granted requester's we/addr/wdata, and pulse its gnt.
  - WAIT: reads only; count MEM_LAT cycles.
- Transitions:
  - IDLE → GRANT when any req is high at the edge.
  - GRANT → IDLE if the access is a write.
  - GRANT → WAIT if the access is a read.
  - WAIT → IDLE when the latency counter reaches MEM_LAT.
- Arbitration:
  - Winner is latched into a 1-bit owner register at the IDLE→GRANT edge.
  - If only one req is high, that requester wins.
  - If both are high, the requester not served last wins.
  - The last-served pointer updates at every grant and resets to EXT, so CPU wins the first tie.
- The granted request's we/addr/wdata are latched at the IDLE→GRANT edge. Mem outputs come from these registers, so requester inputs may change after gnt.
- Requester rule: drop or renew req at the edge that ends its gnt cycle. The arbiter never samples req in GRANT or WAIT, so a stale req is never double-served.
- WAIT: counter is loaded with 1 on entry and increments each cycle. In the cycle where counter == MEM_LAT:
  - rdata = mem_rdata (combinational pass-through);
  - the owner's rvalid = 1;
  - next state is IDLE.
- Outputs in IDLE or WAIT: mem_en = mem_we = 0; mem_addr and mem_wdata hold their last values.

## Timing
- Reset values: state IDLE, all gnt/rvalid/mem_en/mem_we = 0, mem_addr = mem_wdata = 0, counter 0, last-served = EXT.
- Reset asserted mid-access aborts the access. No rvalid is produced afterwards, and the memory strobe drops asynchronously.
- Write: req seen at edge N → gnt and mem_en during cycle N+1 → IDLE at N+2. Sustained throughput is 1 write per 2 cycles.
- Read: gnt in cycle N+1 → rvalid in cycle N+1+MEM_LAT → IDLE next. Occupancy is MEM_LAT+2 cycles.
- gnt and rvalid are never high for both requesters in the same cycle.
- A new request is never accepted while WAIT is active.

## Structure
- Shared package nrisc_arb_pkg holds:
  - state encoding: IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2;
  - requester indices: REQ_CPU = 1'b0, REQ_EXT = 1'b1;
  - MEM_LAT legal-range constants.
- One sub-module, nrisc_rr_pick: combinational two-way round-robin choice from (cpu_req, ext_req, last).
- Latency counter and FSM live in the top block. Counter width is 3 bits.

## Test plan
- Reset, then CPU write addr 0x0010, data 0xBEEF:
  - cpu_gnt and mem_en/mem_we high for exactly one cycle, with mem_addr = 0x0010 and mem_wdata = 0xBEEF;
  - no cpu_rvalid.
- EXT read of 0x0020 with MEM_LAT = 1 and memory model returning 0x1234:
  - ext_gnt in cycle 1;
  - ext_rvalid with rdata = 0x1234 in cycle 2;
  - IDLE in cycle 3.
- Both reqs held high for 4 accesses: grants go CPU, EXT, CPU, EXT.
- MEM_LAT = 3, CPU read, with ext_req asserted during WAIT:
  - no ext_gnt until after cpu_rvalid, which comes 3 cycles after cpu_gnt;
  - ext_gnt arrives 2 cycles after cpu_rvalid.
- Assert rst in the second WAIT cycle of a MEM_LAT = 3 read:
  - all outputs 0 immediately;
  - no rvalid ever appears for that read;
  - the next tie is granted to CPU.
- Requester changes addr/wdata the cycle after gnt: mem_addr and mem_wdata stay at the latched values.
